// File: rtl/datapath_seq_ctrl_pkg.sv
// Shared definitions for the datapath sequencing controller.
//   - FSM state encoding
//   - opcode / op-field constants for the supported instruction set
//   - shifter codes
//   - instruction field bit positions
package datapath_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_WR_IMM  = 3'd2,
        ST_GET_A   = 3'd3,
        ST_GET_B   = 3'd4,
        ST_EXEC    = 3'd5,
        ST_WR_REG  = 3'd6
    } state_e;

    // Major opcodes (IR[15:13])
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    // MOV sub-ops (IR[12:11])
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    // ALU sub-ops (IR[12:11]); these double as the datapath ALUop codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Shifter codes
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    // Field low-bit positions
    localparam int OPC_LO  = 13;
    localparam int OP_LO   = 11;
    localparam int RN_LO   = 8;
    localparam int RD_LO   = 5;
    localparam int SH_LO   = 3;
    localparam int RM_LO   = 0;
    localparam int IMM_W   = 8;

endpackage

// File: rtl/datapath_seq_ctrl_inst_decoder.sv
// Combinational instruction decoder.
//   ir_i        : instruction register contents
//   rn_o/rd_o/rm_o : register-number fields
//   sh_o, op_o  : shift code and sub-op field
//   sximm8_o    : sign-extended imm8
//   is_*_o      : instruction class flags (is_alu covers ADD/CMP/AND/MVN)
module datapath_seq_ctrl_inst_decoder
    import datapath_seq_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic [DW-1:0] ir_i,
    output logic [RW-1:0] rn_o,
    output logic [RW-1:0] rd_o,
    output logic [RW-1:0] rm_o,
    output logic [1:0]    sh_o,
    output logic [1:0]    op_o,
    output logic [DW-1:0] sximm8_o,
    output logic          is_movi_o,
    output logic          is_movr_o,
    output logic          is_alu_o,
    output logic          is_cmp_o,
    output logic          is_illegal_o
);

    logic [2:0] opcode;

    assign opcode = ir_i[OPC_LO +: 3];
    assign op_o   = ir_i[OP_LO +: 2];
    assign rn_o   = ir_i[RN_LO +: RW];
    assign rd_o   = ir_i[RD_LO +: RW];
    assign sh_o   = ir_i[SH_LO +: 2];
    assign rm_o   = ir_i[RM_LO +: RW];

    // Sign extension of the low byte
    assign sximm8_o[IMM_W-1:0] = ir_i[IMM_W-1:0];
    genvar gi;
    generate
        for (gi = IMM_W; gi < DW; gi++) begin : g_sx
            assign sximm8_o[gi] = ir_i[IMM_W-1];
        end
    endgenerate

    assign is_movi_o    = (opcode == OP_MOV) && (op_o == MOV_IMM);
    assign is_movr_o    = (opcode == OP_MOV) && (op_o == MOV_REG);
    assign is_alu_o     = (opcode == OP_ALU);
    assign is_cmp_o     = is_alu_o && (op_o == ALU_CMP);
    assign is_illegal_o = !(is_movi_o || is_movr_o || is_alu_o);

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Moore FSM sequencing one instruction per start handshake onto the datapath.
//   clk, reset     : clock, synchronous active-high reset
//   s, in          : start request and instruction (captured in WAIT)
//   w              : ready (high only in WAIT)
//   done           : one-cycle pulse in the first WAIT cycle after a legal instruction
//   illegal        : sticky flag for undecodable instructions, cleared on accept
//   readnum..ALUop : datapath control inputs
//   datapath_in    : sign-extended imm8 of IR
module datapath_seq_ctrl
    import datapath_seq_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [DW-1:0] in,
    output logic          w,
    output logic          done,
    output logic          illegal,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic          loadc,
    output logic          loads,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] datapath_in
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q;
    logic          done_q, done_d;
    logic          illegal_q;

    logic [RW-1:0] rn, rd, rm;
    logic [1:0]    sh, op;
    logic          is_movi, is_movr, is_alu, is_cmp, is_illegal;

    datapath_seq_ctrl_inst_decoder #(
        .DW (DW),
        .RW (RW)
    ) u_dec (
        .ir_i         (ir_q),
        .rn_o         (rn),
        .rd_o         (rd),
        .rm_o         (rm),
        .sh_o         (sh),
        .op_o         (op),
        .sximm8_o     (datapath_in),
        .is_movi_o    (is_movi),
        .is_movr_o    (is_movr),
        .is_alu_o     (is_alu),
        .is_cmp_o     (is_cmp),
        .is_illegal_o (is_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   if (s) state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_movi)                        state_d = ST_WR_IMM;
                else if (is_movr)                   state_d = ST_GET_B;
                else if (is_alu && op == ALU_MVN)   state_d = ST_GET_B;
                else if (is_alu)                    state_d = ST_GET_A;
                else                                state_d = ST_WAIT;
            end
            ST_WR_IMM: state_d = ST_WAIT;
            ST_GET_A:  state_d = ST_GET_B;
            ST_GET_B:  state_d = ST_EXEC;
            ST_EXEC:   state_d = is_cmp ? ST_WAIT : ST_WR_REG;
            ST_WR_REG: state_d = ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
    end

    // done fires on the edge that returns a legal instruction to WAIT
    assign done_d = (state_q == ST_WR_IMM) || (state_q == ST_WR_REG) ||
                    ((state_q == ST_EXEC) && is_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state_q == ST_WAIT && s) begin
                ir_q      <= in;
                illegal_q <= 1'b0;
            end else if (state_q == ST_DECODE && is_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign done    = done_q;
    assign illegal = illegal_q;

    // Output logic
    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        shift    = SH_NONE;
        ALUop    = ALU_ADD;
        case (state_q)
            ST_WAIT:   w = 1'b1;
            ST_WR_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_EXEC: begin
                shift = sh;
                // MOV reg passes the shifted B operand through 0 + B
                asel  = is_movr;
                ALUop = is_movr ? ALU_ADD : op;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            ST_WR_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: ;
        endcase
        // A reset edge must never commit architectural state, even mid-instruction
        if (reset) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
        end
    end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Directed bench for datapath_seq_ctrl with a small behavioural datapath
// (regfile, A/B/C, Z flag, shifter, ALU) driven by the controller outputs.
module tb_datapath_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w, done, illegal;
    logic [2:0]  readnum, writenum;
    logic        write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    always #5 clk = ~clk;

    datapath_seq_ctrl #(.DW(16), .RW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (s),
        .in          (in),
        .w           (w),
        .done        (done),
        .illegal     (illegal),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .asel        (asel),
        .bsel        (bsel),
        .loadc       (loadc),
        .loads       (loads),
        .shift       (shift),
        .ALUop       (ALUop),
        .datapath_in (datapath_in)
    );

    // Behavioural datapath
    logic [15:0] rf [0:7];
    logic [15:0] a_q, b_q, c_q, sh_out, ain, bin, alu_out;
    logic        z_q;
    logic        pre_en;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;

    always_comb begin
        case (shift)
            2'b00:   sh_out = b_q;
            2'b01:   sh_out = {b_q[14:0], 1'b0};
            2'b10:   sh_out = {1'b0, b_q[15:1]};
            default: sh_out = {b_q[15], b_q[15:1]};
        endcase
        ain = asel ? 16'h0 : a_q;
        bin = bsel ? 16'h0 : sh_out;
        case (ALUop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (write)  rf[writenum] <= vsel ? datapath_in : c_q;
        if (pre_en) rf[pre_addr] <= pre_data;
        if (loada)  a_q <= rf[readnum];
        if (loadb)  b_q <= rf[readnum];
        if (loadc)  c_q <= alu_out;
        if (loads)  z_q <= (alu_out == 16'h0);
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Per-instruction observations
    int   busy, writes, loadc_cnt, done_busy;
    logic [2:0] last_wnum;
    logic       last_vsel;

    // Called at a sample point (#1 after posedge). Returns at the first WAIT
    // cycle after the instruction, without consuming it.
    task automatic run_instr(input string tag, input logic [15:0] ins,
                             input int exp_busy, input logic exp_done);
        int n;
        n = 0;
        while (!w && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!w) chk({tag, "_ready_timeout"}, 0, 1);
        s  = 1'b1;
        in = ins;
        @(posedge clk); #1;
        s  = 1'b0;
        busy = 0; writes = 0; loadc_cnt = 0; done_busy = 0;
        while (!w && busy < 20) begin
            busy++;
            if (write) begin
                writes++;
                last_wnum = writenum;
                last_vsel = vsel;
            end
            if (loadc) loadc_cnt++;
            if (done)  done_busy++;
            @(posedge clk); #1;
        end
        $display("instr %s %h busy=%0d writes=%0d done=%0b illegal=%0b",
                 tag, ins, busy, writes, done, illegal);
        chk({tag, "_busy"}, busy, exp_busy);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_done_in_busy"}, done_busy, 0);
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; in = 16'h0;
        pre_en = 1'b0; pre_addr = 3'd0; pre_data = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w", {31'd0, w}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_illegal", {31'd0, illegal}, 0);
        chk("rst_write", {31'd0, write}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_instr("movi_r3", 16'hD32A, 2, 1'b1);
        chk("movi_r3_writes", writes, 1);
        run_instr("movi_r5", 16'hD50D, 2, 1'b1);
        chk("r3", rf[3], 16'h002A);
        chk("r5", rf[5], 16'h000D);

        run_instr("add_r2", 16'hA543, 5, 1'b1);
        chk("add_writes", writes, 1);
        chk("add_wnum", last_wnum, 3'd2);
        chk("add_vsel", last_vsel, 1'b0);
        chk("r2", rf[2], 16'h0037);

        run_instr("cmp_r3_r5", 16'hAB05, 4, 1'b1);
        chk("cmp1_z", z_q, 1'b0);
        chk("cmp1_writes", writes, 0);
        chk("cmp1_loadc", loadc_cnt, 0);
        run_instr("cmp_r3_r3", 16'hAB03, 4, 1'b1);
        chk("cmp2_z", z_q, 1'b1);
        chk("cmp2_loadc", loadc_cnt, 0);
        chk("cmp_r2_kept", rf[2], 16'h0037);
        chk("cmp_r3_kept", rf[3], 16'h002A);

        run_instr("movr_r1", 16'hC02B, 4, 1'b1);
        chk("r1", rf[1], 16'h0054);
        run_instr("movi_r0", 16'hD0FF, 2, 1'b1);
        chk("r0", rf[0], 16'hFFFF);

        run_instr("illegal", 16'hE000, 1, 1'b0);
        chk("illegal_set", illegal, 1'b1);
        chk("illegal_writes", writes, 0);
        @(posedge clk); #1;
        chk("illegal_sticky", illegal, 1'b1);
        run_instr("movi_r4", 16'hD401, 2, 1'b1);
        chk("illegal_clr", illegal, 1'b0);
        chk("r4", rf[4], 16'h0001);

        // Reset during EXEC of ADD R2,R5,R3
        pre_en = 1'b1; pre_addr = 3'd2; pre_data = 16'h1111;
        @(posedge clk); #1;
        pre_en = 1'b0;
        chk("pre_r2", rf[2], 16'h1111);
        s = 1'b1; in = 16'hA543;
        @(posedge clk); #1;         // DECODE
        s = 1'b0;
        @(posedge clk); #1;         // GET_A
        @(posedge clk); #1;         // GET_B
        @(posedge clk); #1;         // EXEC
        chk("exec_loadc", loadc, 1'b1);
        reset = 1'b1; s = 1'b1;
        #1;
        chk("rst_gate_loadc", loadc, 1'b0);
        chk("rst_gate_write", write, 1'b0);
        @(posedge clk); #1;
        chk("rst_exec_w", w, 1'b1);
        @(posedge clk); #1;
        chk("rst_s_ignored_w", w, 1'b1);
        reset = 1'b0; s = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_w", w, 1'b1);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_r2", rf[2], 16'h1111);
        $display("instr reset_in_exec a543 r2=%h", rf[2]);

        run_instr("add_after_rst", 16'hA543, 5, 1'b1);
        chk("r2_after_rst", rf[2], 16'h0037);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/datapath_seq_ctrl.md
Name: datapath_seq_ctrl

Overview:
- Moore FSM that decodes one 16-bit instruction per start handshake and drives the datapath's control inputs: regfile read/write, A/B/C/status loads, shifter, ALU and source muxes.
- Sits between the instruction source and the datapath. Replaces the hand-sequenced control steps used in datapath bring-up.
- Supports MOV imm, MOV reg (with shift), ADD, CMP, AND and MVN. All other encodings are flagged illegal.

Parameters:
- DW, 16, datapath word width; must match the datapath.
- RW, 3, register-number width (8 registers).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- s  in  1  start request; sampled only in WAIT.
- in  in  DW  instruction; captured into IR when s accepted.
- w  out  1  ready: 1 only in WAIT.
- done  out  1  registered one-cycle pulse on the cycle after a legal instruction completes.
- illegal  out  1  sticky: set when an undecodable instruction is decoded; cleared on the next accept or on reset.
- readnum  out  RW  to datapath.
- writenum  out  RW  to datapath.
- write  out  1  to datapath.
- vsel  out  1  to datapath; 1 selects datapath_in.
- loada  out  1  to datapath.
- loadb  out  1  to datapath.
- asel  out  1  to datapath; 1 forces A operand to 0.
- bsel  out  1  to datapath.
- loadc  out  1  to datapath.
- loads  out  1  to datapath.
- shift  out  2  to datapath.
- ALUop  out  2  to datapath.
- datapath_in  out  DW  sign-extended imm8 of IR, driven continuously.

Behaviour:
- Encoding: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
- Legal encodings:
  - 110/10 = MOV Rn,#imm8
  - 110/00 = MOV Rd,Rm{sh}
  - 101/00 = ADD Rd,Rn,Rm{sh}
  - 101/01 = CMP Rn,Rm{sh}
  - 101/10 = AND
  - 101/11 = MVN Rd,Rm{sh}
  - Anything else is illegal.
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_REG.
- Control defaults: every control output is 0 unless listed for the current state.
- WAIT: w=1. On s=1, at the edge: IR<=in, illegal<=0, go to DECODE. s is ignored in every other state.
- DECODE transitions:
  - MOV imm -> WR_IMM
  - ADD/CMP/AND -> GET_A
  - MOV reg/MVN -> GET_B
  - illegal -> WAIT, illegal<=1, no done pulse.
- WR_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC: shift=sh, bsel=0.
  - MOV reg: asel=1, ALUop=00.
  - Otherwise: asel=0, ALUop=op.
  - loadc=1 for all except CMP.
  - loads=1 only for CMP.
  - Next state: CMP -> WAIT; all others -> WR_REG.
- WR_REG: writenum=Rd, vsel=0, write=1 -> WAIT.
- Busy cycles (w=0):
  - MOV imm: 2
  - MOV reg and MVN: 4
  - CMP: 4
  - ADD and AND: 5
  - illegal: 1
- done: asserted in the first WAIT cycle after a legal instruction; deasserted the following cycle.
- Reset:
  - state<=WAIT, IR<=0, done<=0, illegal<=0.
  - While reset=1, write/loada/loadb/loadc/loads are forced to 0, so no architectural update occurs on a reset edge, including mid-instruction.
- Simultaneous s and reset: reset wins and the instruction is dropped.
- Back-to-back: s held high in WAIT accepts a new instruction every time WAIT is entered. There are no dead cycles beyond WAIT itself.

Decomposition:
- Shared package/header: state encodings; opcode/op constants (OP_MOV=3'b110, OP_ALU=3'b101, ALU_ADD/CMP/AND/MVN); shift codes; field bit positions.
- One sub-module, inst_decoder: combinational. IR in; Rn/Rd/Rm/sh/op, sximm8 and class flags (is_movi, is_movr, is_alu, is_cmp, is_illegal) out.
- The FSM lives in the top module.

Test Plan:
- MOV R3,#42 (in=16'hD32A), then MOV R5,#13 (16'hD50D) -> R3=16'h002A, R5=16'h000D; w low exactly 2 cycles each; done pulses once each.
- ADD R2,R5,R3 (16'hA543) -> R2=16'h0037; w low 5 cycles; exactly one write, in WR_REG with writenum=2, vsel=0.
- CMP R3,R5 (16'hAB05) -> Z_out=0, no register changes; then CMP R3,R3 (16'hAB03) -> Z_out=1; loadc never asserted; 4 busy cycles.
- MOV R1,R3,LSL#1 (16'hC02B) -> R1=16'h0054; MOV R0,#-1 (16'hD0FF) -> R0=16'hFFFF (sign extension).
- Illegal 16'hE000 -> illegal=1 after 1 busy cycle, no done, no register write; next accept of MOV R4,#1 (16'hD401) clears illegal and R4=16'h0001.
- Reset asserted during EXEC of ADD R2,R5,R3 with R2 preloaded to 16'h1111 -> R2 stays 16'h1111; w=1 the cycle after reset; s held with reset high is not accepted.
